mul_qb_f: RTL and testbench
===========================

# mul_qb_f

Sequential shift-add reconstructor that computes A = Q·B + F from a quotient, divisor and remainder. It is the inverse of the lab's divider: it takes the divider's Q/B/F outputs and rebuilds the dividend. It sits beside the divider in the lab top level for round-trip self-checking and uses the same start/done handshake style: level `st` in, one-cycle done pulse out.

## Interface
- `WQ`, 22, quotient width.
- `WB`, 5, divisor and remainder width; also the iteration count.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Q`  in  WQ  quotient operand.
- `B`  in  WB  divisor operand.
- `F`  in  WB  remainder operand.
- `st`  in  1  start request; only a rising edge is acted on.
- `A`  out  WQ+WB  result Q·B+F; held until the next completion.
- `ok_mul`  out  1  one-cycle done pulse.
- `err`  out  1  remainder invalid (F ≥ B, which includes B = 0); valid while `ok_mul` is high and held afterwards.
- `bf_acc`  out  WQ+WB  accumulator debug view. Present only with MUL_QB_F_DBG_EN.
- `bf_b`  out  WB  shifting-multiplier debug view. Present only with MUL_QB_F_DBG_EN.

## Operation
- States:
  - IDLE: waiting for a start.
  - ADD: WB iterations.
  - DONE: write the result.
- Start detection:
  - `st` is registered into `st_d`.
  - start = `st & ~st_d`, acted on only in IDLE.
  - A start edge that occurs in ADD or DONE is discarded, not queued.
- IDLE → ADD on start. On that edge:
  - acc ← zero-extended F; mq ← zero-extended Q; mb ← B; cnt ← 0.
  - err_r ← (F ≥ B).
- ADD, every cycle:
  - If mb[0], acc ← acc + mq.
  - mq ← mq << 1; mb ← mb >> 1; cnt ← cnt + 1.
  - When cnt = WB−1, go to DONE.
- DONE → IDLE on the next edge. On that edge: A ← acc, err ← err_r, ok_mul ← 1.
- `ok_mul` clears on the following edge.
- Arithmetic:
  - Width WQ+WB.
  - The maximum result (2^WQ−1)(2^WB−1) + 2^WB−2 fits, so no overflow is possible and there is no carry-out.
- An invalid remainder (F ≥ B) still produces the exact Q·B+F; only `err` flags it.

## Timing
- Start sampled on edge k. ADD occupies edges k+1 … k+WB. DONE is edge k+WB+1.
- `A`, `err` and `ok_mul` update on edge k+WB+1, so `ok_mul` is high for exactly one cycle.
- Latency from start to done is WB+1 = 6 cycles at default widths. The next start is accepted from edge k+WB+2.
- Reset values: `A` = 0, `ok_mul` = 0, `err` = 0, `bf_acc` = 0, `bf_b` = 0. State = IDLE, `st_d` = 0.
- `rst_n` low mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - No `ok_mul` for the aborted operation.
- `st` held high through reset release: `st_d` = 0 after reset, so one start is taken on the first edge.
- `st` held for several cycles produces exactly one operation.

## Configuration
- Macro: MUL_QB_F_DBG_EN.
- Defined:
  - `bf_acc` follows acc each cycle.
  - `bf_b` follows mb each cycle.
  - Both are 0 in reset.
- Undefined: the ports and their registers are absent; the rest of the behaviour is identical.

## Structure
- Shared package `mul_qb_f_pkg` holds:
  - Default widths WQ_DEF = 22 and WB_DEF = 5.
  - Derived WA = WQ+WB.
  - State enum {S_IDLE, S_ADD, S_DONE}.
- Datapath, counter and FSM stay in one module; the shift-add step is too small to justify a sub-module.
- The round-trip checker that pairs this block with the divider lives in the bench, not in RTL.

## Test plan
- Q=1, B=1, F=0, `st` high for 2 cycles → single `ok_mul` pulse 6 cycles after the start edge; A=1, err=0.
- Q=0x3FFFFF, B=31, F=30 → A=0x7BFFFFF, err=0 (maximum result, no overflow).
- Q=5, B=0, F=3 → A=3, err=1.
- Q=100, B=7, F=7 → A=707, err=1.
- Q=1000, B=13, F=12 → A=13012, err=0. Then assert `rst_n` low during the 3rd ADD cycle of a second operation → A=0, ok_mul=0, no late pulse. A fresh `st` edge afterwards completes normally.
- A `st` rising edge in ADD is ignored: exactly one `ok_mul`, and the result belongs to the first operands.

Source files
------------

// File: rtl/mul_qb_f_pkg.sv
// Shared definitions for the mul_qb_f shift-add reconstructor (A = Q*B + F).
// Holds default operand widths, the derived result width and the FSM state type.
package mul_qb_f_pkg;

    // Default quotient width and divisor/remainder width.
    localparam int WQ_DEF = 22;
    localparam int WB_DEF = 5;

    // Result width: Q*B + F always fits in WQ+WB bits.
    localparam int WA_DEF = WQ_DEF + WB_DEF;

    // Controller states: wait for start, WB shift-add steps, publish result.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_e;

    // Width of an iteration counter that must reach wb-1 (at least one bit).
    function automatic int cnt_width(input int wb);
        return (wb > 1) ? $clog2(wb) : 1;
    endfunction

endpackage

// File: rtl/mul_qb_f_if.sv
// Operand/result bundle for mul_qb_f.
// The master drives operands and the level start request; the slave returns
// the result, the remainder-invalid flag and the one-cycle done pulse.
// Optional debug views bf_acc/bf_b exist only when MUL_QB_F_DBG_EN is defined.
interface mul_qb_f_if
    import mul_qb_f_pkg::*;
#(
    parameter int WQ = WQ_DEF,
    parameter int WB = WB_DEF
);
    logic [WQ-1:0]    Q;
    logic [WB-1:0]    B;
    logic [WB-1:0]    F;
    logic             st;
    logic [WQ+WB-1:0] A;
    logic             ok_mul;
    logic             err;
`ifdef MUL_QB_F_DBG_EN
    logic [WQ+WB-1:0] bf_acc;
    logic [WB-1:0]    bf_b;

    modport master (
        output Q, B, F, st,
        input  A, ok_mul, err, bf_acc, bf_b
    );

    modport slave (
        input  Q, B, F, st,
        output A, ok_mul, err, bf_acc, bf_b
    );
`else
    modport master (
        output Q, B, F, st,
        input  A, ok_mul, err
    );

    modport slave (
        input  Q, B, F, st,
        output A, ok_mul, err
    );
`endif

endinterface

// File: rtl/mul_qb_f.sv
// mul_qb_f: sequential shift-add reconstructor computing A = Q*B + F.
// Inverse of the lab divider; used beside it for round-trip checking.
// A rising edge on the level input st, seen in IDLE, starts WB shift-add
// iterations; the result, the err flag (F >= B) and a one-cycle ok_mul pulse
// appear WB+1 cycles after the start edge. Start edges while busy are dropped.
// Optional feature macro: MUL_QB_F_DBG_EN exposes the accumulator (bf_acc)
// and the shifting multiplier (bf_b) on the interface.
module mul_qb_f
    import mul_qb_f_pkg::*;
#(
    // Must match the widths of the connected mul_qb_f_if instance.
    parameter int WQ = WQ_DEF,
    parameter int WB = WB_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_qb_f_if.slave  bus
);

    localparam int WA = WQ + WB;
    localparam int CW = cnt_width(WB);
    localparam logic [CW-1:0] CNT_LAST = CW'(WB - 1);

    state_e        state_q,   state_d;
    logic          st_d_q,    st_d_d;
    logic [WA-1:0] acc_q,     acc_d;
    logic [WA-1:0] mq_q,      mq_d;
    logic [WB-1:0] mb_q,      mb_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          err_r_q,   err_r_d;
    logic [WA-1:0] a_q,       a_d;
    logic          err_q,     err_d;
    logic          ok_mul_q,  ok_mul_d;
    logic          start;

    // Next-state, datapath step and output updates for the shift-add FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missed branch would otherwise infer a latch.
        state_d  = state_q;
        st_d_d   = bus.st;
        acc_d    = acc_q;
        mq_d     = mq_q;
        mb_d     = mb_q;
        cnt_d    = cnt_q;
        err_r_d  = err_r_q;
        a_d      = a_q;
        err_d    = err_q;
        ok_mul_d = 1'b0;

        // Only a rising edge of the level request counts as a start.
        start = bus.st & ~st_d_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADD;
                    acc_d   = WA'(bus.F);
                    mq_d    = WA'(bus.Q);
                    mb_d    = bus.B;
                    cnt_d   = '0;
                    // F >= B also covers B = 0; the sum is still exact.
                    err_r_d = (bus.F >= bus.B);
                end
            end

            S_ADD: begin
                if (mb_q[0]) begin
                    acc_d = acc_q + mq_q;
                end
                mq_d  = mq_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                a_d      = acc_q;
                err_d    = err_r_q;
                ok_mul_d = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation and clears every output.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their _d values from the same pre-edge snapshot.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            st_d_q   <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            err_r_q  <= 1'b0;
            a_q      <= '0;
            err_q    <= 1'b0;
            ok_mul_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_d_q   <= st_d_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            mb_q     <= mb_d;
            cnt_q    <= cnt_d;
            err_r_q  <= err_r_d;
            a_q      <= a_d;
            err_q    <= err_d;
            ok_mul_q <= ok_mul_d;
        end
    end

    assign bus.A      = a_q;
    assign bus.err    = err_q;
    assign bus.ok_mul = ok_mul_q;

`ifdef MUL_QB_F_DBG_EN
    // Debug views track the working registers directly, so they are 0 in reset.
    assign bus.bf_acc = acc_q;
    assign bus.bf_b   = mb_q;
`endif

endmodule

// File: tb/tb_mul_qb_f.sv
// Self-checking bench for mul_qb_f. Expected results come from plain
// arithmetic (Q*B+F, F>=B) and the documented cycle timing: ok_mul appears
// exactly WB+1 edges after the start edge and A/err hold between completions.
module tb_mul_qb_f;
    import mul_qb_f_pkg::*;

    localparam int WQ  = WQ_DEF;
    localparam int WB  = WB_DEF;
    localparam int WA  = WQ + WB;
    localparam int LAT = WB + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul_qb_f_if #(.WQ(WQ), .WB(WB)) bus_if ();

    mul_qb_f #(.WQ(WQ), .WB(WB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Last completed result as seen by the outside world.
    logic [WA-1:0] last_a   = '0;
    logic          last_err = 1'b0;

    function automatic logic [WA-1:0] model_a(input logic [WQ-1:0] q,
                                              input logic [WB-1:0] b,
                                              input logic [WB-1:0] f);
        longint unsigned r;
        r = q;
        r = r * b + f;
        return r[WA-1:0];
    endfunction

    // Advance to 1 time unit after the next rising edge (sampling point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation. Edge n=0 is the start edge; st drops at n==hold and
    // rises again at n==restart_at. If st is still high afterwards, a quiet
    // window checks that no further operation starts.
    task automatic run_op(input string name,
                          input logic [WQ-1:0] q,
                          input logic [WB-1:0] b,
                          input logic [WB-1:0] f,
                          input int hold,
                          input int restart_at,
                          input bit release_rst);
        logic [WA-1:0] exp_a;
        logic          exp_err;
        exp_a   = model_a(q, b, f);
        exp_err = (f >= b);

        bus_if.Q  = q;
        bus_if.B  = b;
        bus_if.F  = f;
        bus_if.st = 1'b1;
        if (release_rst) rst_n = 1'b1;

        for (int n = 0; n <= LAT; n++) begin
            tick();
            if (n == 0) begin
`ifdef MUL_QB_F_DBG_EN
                checks++;
                if (bus_if.bf_b !== b || bus_if.bf_acc !== WA'(f)) begin
                    errors++;
                    $display("FAIL %s dbg_load: bf_b=%h bf_acc=%h, required bf_b=%h bf_acc=%h",
                             name, bus_if.bf_b, bus_if.bf_acc, b, WA'(f));
                end
`endif
                // Operands are latched at start; later changes must not matter.
                bus_if.Q = WQ'($urandom);
                bus_if.B = WB'($urandom);
                bus_if.F = WB'($urandom);
            end
            if (n == hold)       bus_if.st = 1'b0;
            if (n == restart_at) bus_if.st = 1'b1;

            checks++;
            if (n < LAT) begin
                if (bus_if.ok_mul !== 1'b0 || bus_if.A !== last_a || bus_if.err !== last_err) begin
                    errors++;
                    $display("FAIL %s busy edge %0d: ok_mul=%b A=%h err=%b, required ok_mul=0 A=%h err=%b",
                             name, n, bus_if.ok_mul, bus_if.A, bus_if.err, last_a, last_err);
                end
            end else begin
                if (bus_if.ok_mul !== 1'b1 || bus_if.A !== exp_a || bus_if.err !== exp_err) begin
                    errors++;
                    $display("FAIL %s done edge %0d: ok_mul=%b A=%h err=%b, required ok_mul=1 A=%h err=%b",
                             name, n, bus_if.ok_mul, bus_if.A, bus_if.err, exp_a, exp_err);
                end
            end
        end
        last_a   = exp_a;
        last_err = exp_err;

        if (bus_if.st) begin
            for (int m = 0; m < LAT + 2; m++) begin
                tick();
                if (m == 1) bus_if.st = 1'b0;
                checks++;
                if (bus_if.ok_mul !== 1'b0 || bus_if.A !== last_a || bus_if.err !== last_err) begin
                    errors++;
                    $display("FAIL %s quiet %0d: ok_mul=%b A=%h err=%b, required ok_mul=0 A=%h err=%b",
                             name, m, bus_if.ok_mul, bus_if.A, bus_if.err, last_a, last_err);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus_if.st = 1'b0;
        bus_if.Q  = '0;
        bus_if.B  = '0;
        bus_if.F  = '0;
        tick();
        tick();
        checks++;
        if (bus_if.A !== '0 || bus_if.ok_mul !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: A=%h ok_mul=%b err=%b, required all 0",
                     bus_if.A, bus_if.ok_mul, bus_if.err);
        end
`ifdef MUL_QB_F_DBG_EN
        checks++;
        if (bus_if.bf_acc !== '0 || bus_if.bf_b !== '0) begin
            errors++;
            $display("FAIL reset_dbg: bf_acc=%h bf_b=%h, required 0", bus_if.bf_acc, bus_if.bf_b);
        end
`endif
    endtask

    // st already high while in reset: the first edge after release starts.
    task automatic test_st_through_reset();
        run_op("st_thru_rst", 22'd1, 5'd1, 5'd0, 1, -1, 1'b1);
    endtask

    // Spec vectors, issued back to back (next start at k+WB+2).
    task automatic test_back_to_back();
        run_op("max_result", 22'h3FFFFF, 5'd31, 5'd30, 0, -1, 1'b0);
        checks++;
        if (last_a !== 27'h7BFFFFF) begin
            errors++;
            $display("FAIL max_model: model=%h, required 7bfffff", last_a);
        end
        run_op("b_zero",   22'd5,   5'd0, 5'd3, 0, -1, 1'b0);
        run_op("f_eq_b",   22'd100, 5'd7, 5'd7, 0, -1, 1'b0);
        run_op("zero_q",   22'd0,   5'd9, 5'd4, 0, -1, 1'b0);
    endtask

    // A completed op, then a reset during the 3rd ADD cycle of the next one.
    task automatic test_abort_reset();
        run_op("pre_abort", 22'd1000, 5'd13, 5'd12, 0, -1, 1'b0);
        bus_if.Q  = 22'h2ABCDE;
        bus_if.B  = 5'd21;
        bus_if.F  = 5'd4;
        bus_if.st = 1'b1;
        tick();              // start edge k
        bus_if.st = 1'b0;
        tick();              // k+1
        tick();              // k+2: now in the 3rd ADD cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.A !== '0 || bus_if.ok_mul !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: A=%h ok_mul=%b err=%b, required all 0",
                     bus_if.A, bus_if.ok_mul, bus_if.err);
        end
        tick();
        tick();
        rst_n    = 1'b1;
        last_a   = '0;
        last_err = 1'b0;
        for (int m = 0; m < LAT + 3; m++) begin
            tick();
            checks++;
            if (bus_if.ok_mul !== 1'b0 || bus_if.A !== '0) begin
                errors++;
                $display("FAIL abort_late_%0d: ok_mul=%b A=%h, required ok_mul=0 A=0",
                         m, bus_if.ok_mul, bus_if.A);
            end
        end
        run_op("post_abort", 22'd77, 5'd11, 5'd2, 0, -1, 1'b0);
    endtask

    // A fresh rising edge of st during ADD must be dropped.
    task automatic test_edge_in_add();
        run_op("edge_in_add", 22'd123456, 5'd25, 5'd17, 0, 2, 1'b0);
    endtask

    // st held high well past completion yields one operation only.
    task automatic test_long_hold();
        run_op("long_hold", 22'd4321, 5'd3, 5'd1, 100, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [WQ-1:0] q;
        logic [WB-1:0] b;
        logic [WB-1:0] f;
        for (int i = 0; i < 40; i++) begin
            q = WQ'($urandom);
            b = WB'($urandom);
            if (b != 0 && $urandom_range(0, 3) != 0) f = WB'($urandom_range(0, int'(b) - 1));
            else                                     f = WB'($urandom);
            run_op("random", q, b, f, $urandom_range(0, 3), -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_st_through_reset();
        test_back_to_back();
        test_abort_reset();
        test_edge_in_add();
        test_long_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
